rx_frame_ctrl: RTL and testbench
================================

# rx_frame_ctrl

Receive-side controller sitting between the UART receive frontend and the Wishbone register file. Takes each raw frame word from the frontend and aligns it according to the active character format. Checks parity and stop bits, and buffers the decoded characters with per-character error flags in a small FIFO. Generates the receive status flags, the sticky overrun flag and the receive interrupt.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in characters; power of two, 2..16.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- cr_ds_i  in  1  data size: 0 = 7 bits, 1 = 8 bits.
- cr_p_i  in  2  parity: 00 none, 01 even, 10 odd, 11 treated as odd.
- cr_s_i  in  1  stop bits: 0 = one, 1 = two.
- cr_rxne_ie_i  in  1  interrupt enable, FIFO not empty.
- cr_err_ie_i  in  1  interrupt enable, errors.
- frame_i  in  11  raw frame; serial bits shifted in at bit 10, so the last-received bit is bit 10.
- frame_valid_i  in  1  one-cycle strobe, frame_i complete.
- rd_i  in  1  pop head character (one pop per cycle high).
- clr_ovr_i  in  1  clear sticky overrun.
- rd_data_o  out  8  head character, zero-extended for 7-bit format.
- rd_pe_o  out  1  head parity error.
- rd_fe_o  out  1  head framing error.
- rx_empty_o  out  1  FIFO empty.
- rx_full_o  out  1  FIFO full.
- ovr_o  out  1  sticky overrun.
- irq_o  out  1  interrupt, registered.

## Operation
- **Capture stage:** on frame_valid_i, register frame_i and snapshot cr_ds_i/cr_p_i/cr_s_i. A format change after capture does not affect that frame.
- **Decode stage:** runs in the cycle after capture.
  - D = 7 + ds; P = (p != 00); N = D + P + 1 + s.
  - Reception-order bit k is at frame[11 − N + k]. Data is bits 0..D−1, LSB first. Parity is bit D when P = 1. Stop bits are the remaining 1 + s bits.
  - fe = 1 if any stop bit is 0.
  - pe = P and (XOR of data bits XOR parity bit XOR odd) ≠ 0, where odd = p[1].
- **Push:** the decoded entry {fe, pe, data} is written at the end of the decode cycle.
  - If the FIFO is full (count before this cycle's pop equals DEPTH) and rd_i is not high this cycle, the entry is dropped and ovr_o is set.
  - If full and rd_i is high in the same cycle, the push is accepted and count is unchanged.
- **Pop:** rd_i with the FIFO empty is ignored, with no pointer or count change.
- **Overrun clear:** clr_ovr_i clears ovr_o. A set in the same cycle wins.
- **Pointers:** read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- **Head outputs:** rd_data_o/rd_pe_o/rd_fe_o show the head entry combinationally from the storage array. They are 0 when empty.
- **Interrupt:** irq_o next = (cr_rxne_ie_i & !empty) | (cr_err_ie_i & (ovr | (!empty & (head pe | head fe)))).
- **Back-to-back frames:** frame_valid_i may assert on consecutive cycles. The pipeline accepts one frame per cycle with no stall.

## Timing
- **Reset values:** count 0, pointers 0, rx_empty_o 1, rx_full_o 0, ovr_o 0, irq_o 0, rd_* 0, capture valid 0.
- **Reset mid-operation:** a frame in capture/decode is discarded and the FIFO contents are lost.
- **Push latency:** frame_valid_i at cycle T; decode at T+1; rx_empty_o low and rd_data_o valid at T+2; irq_o high at T+3.
- **Pop latency:** rd_i at T; the next head appears at T+1; rx_empty_o rises at T+1 if the last entry was popped.
- **Overrun latency:** ovr_o rises at T+2 for a dropped frame strobed at T.

## Configuration
- **Macro RX_FRAME_CTRL_PARITY_CHECK_EN**
  - Defined: parity is checked as above.
  - Undefined: the parity bit is still skipped for alignment, pe is always 0 and no parity XOR logic is built.

## Test plan
- **8N1 capture:** 8N1, frame_i = 11'b1_1010_0101_xx (stop=1, data 0xA5), strobe at T → rx_empty_o=0 at T+2, rd_data_o=0xA5, pe=fe=0.
- **7E1 parity error:** 7E1, data 0x41, parity bit 1 (wrong) → rd_data_o=0x41, rd_pe_o=1; with cr_err_ie_i=1, irq_o=1 at T+3. With the macro undefined, rd_pe_o=0.
- **8O2 framing error:** 8O2, second stop bit 0 → rd_fe_o=1, rd_pe_o=0 for correct odd parity.
- **Overrun:** DEPTH=4, five frames 0x01..0x05 with no reads → rx_full_o=1, ovr_o=1, 0x05 dropped, pops return 0x01..0x04. clr_ovr_i → ovr_o=0.
- **Full with simultaneous pop:** FIFO full, pop and push in the same cycle → no overrun, count stays 4, order 0x02..0x05.
- **Reset mid-stream:** rst_ni low between strobe and push → after release rx_empty_o=1, irq_o=0. A pop on empty changes nothing.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART receive-side controller.
// Captures raw frames, aligns data to the snapshotted character format, checks parity and
// stop bits, buffers {fe, pe, data} entries in a small FIFO and drives status and irq.
// Optional feature macro: RX_FRAME_CTRL_PARITY_CHECK_EN (when undefined, pe is always 0 and
// no parity XOR logic is built; the parity bit is still skipped for alignment).
module rx_frame_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic        cr_rxne_ie_i,
  input  logic        cr_err_ie_i,
  input  logic [10:0] frame_i,
  input  logic        frame_valid_i,
  input  logic        rd_i,
  input  logic        clr_ovr_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_pe_o,
  output logic        rd_fe_o,
  output logic        rx_empty_o,
  output logic        rx_full_o,
  output logic        ovr_o,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Capture stage
  logic        cap_valid_q;
  logic [10:0] cap_frame_q;
  logic        cap_ds_q;
  logic [1:0]  cap_p_q;
  logic        cap_s_q;

  // Decode results
  logic        par_en;
  logic [3:0]  dlen;
  logic [3:0]  nlen;
  logic [3:0]  base;
  logic [3:0]  stop_pos;
  logic [10:0] aligned;
  logic [7:0]  dec_data;
  logic        dec_pe;
  logic        dec_fe;

  // FIFO state
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          irq_q, irq_d;

  logic       empty, full, push, pop, ovr_set;
  logic [9:0] head;

  // Register the frame and snapshot the format so later format changes cannot affect it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_valid_q <= 1'b0;
      cap_frame_q <= '0;
      cap_ds_q    <= 1'b0;
      cap_p_q     <= 2'b00;
      cap_s_q     <= 1'b0;
    end else begin
      cap_valid_q <= frame_valid_i;
      if (frame_valid_i) begin
        cap_frame_q <= frame_i;
        cap_ds_q    <= cr_ds_i;
        cap_p_q     <= cr_p_i;
        cap_s_q     <= cr_s_i;
      end
    end
  end

  // Align the captured frame so reception-order bit 0 lands at bit 0, then check it.
  always_comb begin
    par_en   = (cap_p_q != 2'b00);
    dlen     = cap_ds_q ? 4'd8 : 4'd7;
    nlen     = dlen + {3'b000, par_en} + 4'd1 + {3'b000, cap_s_q};
    base     = 4'd11 - nlen;
    aligned  = cap_frame_q >> base;
    dec_data = cap_ds_q ? aligned[7:0] : {1'b0, aligned[6:0]};
    stop_pos = dlen + {3'b000, par_en};
    dec_fe   = ~aligned[stop_pos] | (cap_s_q & ~aligned[stop_pos + 4'd1]);
`ifdef RX_FRAME_CTRL_PARITY_CHECK_EN
    // dec_data[7] is zero for 7-bit characters, so the full reduction is safe.
    dec_pe   = par_en & (^dec_data ^ aligned[dlen] ^ cap_p_q[1]);
`else
    dec_pe   = 1'b0;
`endif
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = rd_i & ~empty;
  // A full FIFO still accepts the entry when a pop frees a slot in the same cycle.
  assign push    = cap_valid_q & (~full | rd_i);
  assign ovr_set = cap_valid_q & full & ~rd_i;
  assign head    = mem_q[rptr_q];

  // Next-state for pointers, count, sticky overrun and interrupt.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovr_d   = ovr_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr_i) begin
      ovr_d = 1'b0;
    end
    irq_d = (cr_rxne_ie_i & ~empty) |
            (cr_err_ie_i & (ovr_q | (~empty & (head[8] | head[9]))));
  end

  // FIFO control state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
    end
  end

  // Storage array; contents are don't-care while empty since outputs are gated.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {dec_fe, dec_pe, dec_data};
  end

  assign rd_data_o  = empty ? 8'h00 : head[7:0];
  assign rd_pe_o    = ~empty & head[8];
  assign rd_fe_o    = ~empty & head[9];
  assign rx_empty_o = empty;
  assign rx_full_o  = full;
  assign ovr_o      = ovr_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed and random checks of rx_frame_ctrl against a queue-based model.
module tb_rx_frame_ctrl;
  localparam int unsigned DEPTH = 4;
`ifdef RX_FRAME_CTRL_PARITY_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cr_ds;
  logic [1:0]  cr_p;
  logic        cr_s;
  logic        rxne_ie;
  logic        err_ie;
  logic [10:0] frame;
  logic        frame_valid;
  logic        rd;
  logic        clr_ovr;
  logic [7:0]  rd_data;
  logic        rd_pe, rd_fe, rx_empty, rx_full, ovr, irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [9:0] q[$];
  logic       m_ovr, m_irq, m_cap_v;
  logic [9:0] m_cap;

  always #5 clk = ~clk;

  rx_frame_ctrl #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cr_ds_i(cr_ds), .cr_p_i(cr_p), .cr_s_i(cr_s),
    .cr_rxne_ie_i(rxne_ie), .cr_err_ie_i(err_ie), .frame_i(frame),
    .frame_valid_i(frame_valid), .rd_i(rd), .clr_ovr_i(clr_ovr), .rd_data_o(rd_data),
    .rd_pe_o(rd_pe), .rd_fe_o(rd_fe), .rx_empty_o(rx_empty), .rx_full_o(rx_full),
    .ovr_o(ovr), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode a frame from the format rules: {fe, pe, data}.
  function automatic logic [9:0] dec(input logic [10:0] fr, input logic ds,
                                     input logic [1:0] p, input logic s);
    int d = 7 + int'(ds);
    int pp = (p != 2'b00) ? 1 : 0;
    int n = d + pp + 1 + int'(s);
    int b = 11 - n;
    logic [7:0] data = 8'h00;
    logic x = 1'b0;
    logic pe = 1'b0;
    logic fe = 1'b0;
    for (int k = 0; k < d; k++) begin
      data[k] = fr[b + k];
      x ^= fr[b + k];
    end
    if (pp == 1) pe = x ^ fr[b + d] ^ p[1];
    for (int k = d + pp; k < n; k++) if (!fr[b + k]) fe = 1'b1;
    if (!PAR_CHK) pe = 1'b0;
    return {fe, pe, data};
  endfunction

  // Build a frame in reception order; flip corrupts parity, stop_bad zeroes stop bits.
  function automatic logic [10:0] mkframe(input logic [7:0] data, input logic ds,
                                          input logic [1:0] p, input logic s,
                                          input logic flip, input logic [1:0] stop_bad);
    int d = 7 + int'(ds);
    int pp = (p != 2'b00) ? 1 : 0;
    int n = d + pp + 1 + int'(s);
    int b = 11 - n;
    logic [10:0] f = 11'($urandom);
    logic x = 1'b0;
    for (int k = 0; k < d; k++) begin
      f[b + k] = data[k];
      x ^= data[k];
    end
    if (pp == 1) f[b + d] = x ^ p[1] ^ flip;
    for (int j = 0; j < 1 + int'(s); j++) f[b + d + pp + j] = ~stop_bad[j];
    return f;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovr   = 1'b0;
    m_irq   = 1'b0;
    m_cap_v = 1'b0;
    m_cap   = '0;
  endtask

  // One clock edge of the model, using the inputs driven during the cycle.
  task automatic model_edge(input logic fv_a, input logic [10:0] fr_a, input logic rd_a,
                            input logic clr_a);
    int sz = q.size();
    logic [9:0] hd = (sz > 0) ? q[0] : 10'h000;
    logic set = 1'b0;
    logic irq_n;
    irq_n = (rxne_ie && sz > 0) || (err_ie && (m_ovr || (sz > 0 && hd[9:8] != 2'b00)));
    if (rd_a && sz > 0) void'(q.pop_front());
    if (m_cap_v) begin
      if (sz == DEPTH && !rd_a) set = 1'b1;
      else q.push_back(m_cap);
    end
    if (set) m_ovr = 1'b1;
    else if (clr_a) m_ovr = 1'b0;
    m_irq   = irq_n;
    m_cap_v = fv_a;
    m_cap   = dec(fr_a, cr_ds, cr_p, cr_s);
  endtask

  task automatic compare_all();
    logic [9:0] hd = (q.size() > 0) ? q[0] : 10'h000;
    chk("empty", 32'(rx_empty), 32'(q.size() == 0));
    chk("full", 32'(rx_full), 32'(q.size() == DEPTH));
    chk("ovr", 32'(ovr), 32'(m_ovr));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("rd_data", 32'(rd_data), 32'(hd[7:0]));
    chk("rd_pe", 32'(rd_pe), 32'(hd[8]));
    chk("rd_fe", 32'(rd_fe), 32'(hd[9]));
  endtask

  task automatic cycle(input logic fv_a, input logic [10:0] fr_a, input logic rd_a,
                       input logic clr_a);
    frame_valid = fv_a;
    frame       = fr_a;
    rd          = rd_a;
    clr_ovr     = clr_a;
    @(posedge clk);
    model_edge(fv_a, fr_a, rd_a, clr_a);
    #1;
    compare_all();
  endtask

  initial begin
    logic [10:0] f;
    rst_n = 1'b0; cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
    rxne_ie = 1'b0; err_ie = 1'b0; frame = '0; frame_valid = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // 8N1 capture, literal frame with data 0xA5
    f = 11'b1_1010_0101_00;
    cycle(1'b1, f, 1'b0, 1'b0);
    chk("8n1_empty_t1", 32'(rx_empty), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("8n1_data", 32'(rd_data), 32'hA5);
    chk("8n1_flags", 32'({rd_fe, rd_pe}), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 7E1 with wrong parity bit
    cr_ds = 1'b0; cr_p = 2'b01; cr_s = 1'b0; err_ie = 1'b1;
    cycle(1'b1, mkframe(8'h41, 1'b0, 2'b01, 1'b0, 1'b1, 2'b00), 1'b0, 1'b0);
    cr_ds = 1'b1; cr_p = 2'b00;  // format change after capture must not matter
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("7e1_data", 32'(rd_data), 32'h41);
    chk("7e1_pe", 32'(rd_pe), 32'(PAR_CHK));
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("7e1_irq", 32'(irq), 32'(PAR_CHK));
    cycle(1'b0, '0, 1'b1, 1'b0);
    err_ie = 1'b0;
    cycle(1'b0, '0, 1'b0, 1'b0);

    // 8O2 with second stop bit low
    cr_ds = 1'b1; cr_p = 2'b10; cr_s = 1'b1;
    cycle(1'b1, mkframe(8'h3C, 1'b1, 2'b10, 1'b1, 1'b0, 2'b10), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("8o2_fe", 32'(rd_fe), 32'd1);
    chk("8o2_pe", 32'(rd_pe), 32'd0);
    chk("8o2_data", 32'(rd_data), 32'h3C);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Overrun: five back-to-back frames, no reads
    cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
    for (int i = 1; i <= 5; i++) cycle(1'b1, mkframe(8'(i), 1'b1, 2'b00, 1'b0, 1'b0, 2'b00),
                                       1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("ovr_full", 32'(rx_full), 32'd1);
    chk("ovr_set", 32'(ovr), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_pop", 32'(rd_data), 32'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("ovr_drained", 32'(rx_empty), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(ovr), 32'd0);

    // Full with simultaneous pop and push
    for (int i = 1; i <= 5; i++) cycle(1'b1, mkframe(8'(i), 1'b1, 2'b00, 1'b0, 1'b0, 2'b00),
                                       1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("fullpop_ovr", 32'(ovr), 32'd0);
    chk("fullpop_full", 32'(rx_full), 32'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("fullpop_order", 32'(rd_data), 32'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // Reset between strobe and push
    rxne_ie = 1'b1;
    cycle(1'b1, mkframe(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);
    frame_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("rst_empty", 32'(rx_empty), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("pop_empty", 32'(rx_empty), 32'd0 + 32'(q.size() == 0));
    cycle(1'b1, mkframe(8'h77, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("pop_empty_ptr", 32'(rd_data), 32'h77);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      cr_ds = 1'($urandom);
      cr_p  = 2'($urandom);
      cr_s  = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        rxne_ie = 1'($urandom);
        err_ie  = 1'($urandom);
      end
      cycle(1'($urandom_range(0, 1)), 11'($urandom), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 19) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
